// File: rtl/recv_pc_to_ram32.sv
// recv_pc_to_ram32
//   Receives 8N1 UART bytes from a PC and packs every four of them
//   (little-endian, first byte in [7:0]) into a 32-bit word written to RAM.
//   One write strobe is issued per word, at consecutive addresses from
//   startAddr through endAddr. The address wraps modulo 2^WIDTHofADDR.
//   A one-cycle ok pulse closes the session.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit.
//   WIDTHofADDR  : RAM address width.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   recvSig   in   one-cycle arm pulse, ignored while busy
//   startAddr in   first word address, latched on accepted recvSig
//   endAddr   in   last word address, latched on accepted recvSig
//   rs232_rx  in   UART RX line, idle high, asynchronous to clk
//   write     out  one-cycle RAM write strobe
//   addr      out  RAM address, valid while write=1
//   data      out  RAM write data, valid while write=1
//   busy      out  session in progress, from accepted recvSig until ok
//   ok        out  one-cycle pulse after the endAddr word is written
//   frameErr  out  one-cycle pulse when a stop bit is sampled low

module recv_pc_to_ram32 #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WIDTHofADDR  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   recvSig,
  input  logic [WIDTHofADDR-1:0] startAddr,
  input  logic [WIDTHofADDR-1:0] endAddr,
  input  logic                   rs232_rx,
  output logic                   write,
  output logic [WIDTHofADDR-1:0] addr,
  output logic [31:0]            data,
  output logic                   busy,
  output logic                   ok,
  output logic                   frameErr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {W_IDLE, W_RECV, W_WRITE, W_DONE} w_state_e;

  // Bit-level receiver state
  rx_state_e       rx_state_q;
  logic            rx_meta_q;
  logic            rx_sync_q;
  logic            rx_prev_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic            frame_err_q;
  logic            rx_tick;
  logic            byte_vld_d;

  // Word assembler state
  w_state_e               w_state_q;
  logic [WIDTHofADDR-1:0] addr_q;
  logic [WIDTHofADDR-1:0] addr_d;
  logic [WIDTHofADDR-1:0] end_q;
  logic [31:0]            data_q;
  logic [1:0]             byte_cnt_q;
  logic                   write_q;
  logic                   busy_q;
  logic                   ok_q;

  assign rx_tick = (rx_cnt_q == BIT_MAX);

  // A good byte is recognised in the stop-bit sample cycle itself, so the
  // word FSM can raise write on the very next cycle.
  assign byte_vld_d = (rx_state_q == RX_STOP) && rx_tick && rx_sync_q;

  assign addr_d = addr_q + WIDTHofADDR'(1);

  // ---------------------------------------------------------------------
  // Synchronizer and bit FSM. Counting restarts at the start-bit midpoint,
  // so every later sample lands near the middle of its bit.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rs232_rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      frame_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_MAX) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            // Line back high at mid start bit: treat it as a glitch.
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_cnt_q    <= '0;
            frame_err_q <= !rx_sync_q;
            rx_state_q  <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Word FSM. Bytes arriving outside W_RECV are dropped. This includes a
  // byte that completes in the same cycle as the arming pulse.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      addr_q     <= '0;
      end_q      <= '0;
      data_q     <= '0;
      byte_cnt_q <= '0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      write_q <= 1'b0;
      ok_q    <= 1'b0;
      case (w_state_q)
        W_IDLE: begin
          if (recvSig) begin
            addr_q     <= startAddr;
            end_q      <= endAddr;
            byte_cnt_q <= '0;
            busy_q     <= 1'b1;
            w_state_q  <= W_RECV;
          end
        end
        W_RECV: begin
          if (byte_vld_d) begin
            case (byte_cnt_q)
              2'd0:    data_q[7:0]   <= rx_shift_q;
              2'd1:    data_q[15:8]  <= rx_shift_q;
              2'd2:    data_q[23:16] <= rx_shift_q;
              default: data_q[31:24] <= rx_shift_q;
            endcase
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              write_q   <= 1'b1;
              w_state_q <= W_WRITE;
            end
          end
        end
        W_WRITE: begin
          if (addr_q != end_q) begin
            addr_q     <= addr_d;
            byte_cnt_q <= '0;
            w_state_q  <= W_RECV;
          end else begin
            ok_q      <= 1'b1;
            w_state_q <= W_DONE;
          end
        end
        W_DONE: begin
          busy_q    <= 1'b0;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign write    = write_q;
  assign addr     = addr_q;
  assign data     = data_q;
  assign busy     = busy_q;
  assign ok       = ok_q;
  assign frameErr = frame_err_q;

endmodule

// File: tb/tb_recv_pc_to_ram32.sv
module tb_recv_pc_to_ram32;

  localparam int CPB = 16;
  localparam int AW  = 16;

  logic          clk;
  logic          rst_n;
  logic          recvSig;
  logic [AW-1:0] startAddr;
  logic [AW-1:0] endAddr;
  logic          rs232_rx;
  logic          write;
  logic [AW-1:0] addr;
  logic [31:0]   data;
  logic          busy;
  logic          ok;
  logic          frameErr;

  recv_pc_to_ram32 #(.CLKS_PER_BIT(CPB), .WIDTHofADDR(AW)) dut (
    .clk(clk), .rst_n(rst_n), .recvSig(recvSig), .startAddr(startAddr),
    .endAddr(endAddr), .rs232_rx(rs232_rx), .write(write), .addr(addr),
    .data(data), .busy(busy), .ok(ok), .frameErr(frameErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic          last;
  } wr_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected-behaviour model: the session as the PC sees it
  wr_t           exp_q[$];
  bit            m_armed   = 1'b0;
  logic [AW-1:0] m_addr    = '0;
  logic [AW-1:0] m_end     = '0;
  logic [31:0]   m_word    = '0;
  int            m_nb      = 0;
  bit            exp_busy  = 1'b0;
  int            ferr_pend = 0;
  int            since_last = 100;

  // Observation log
  logic [AW-1:0] log_a[$];
  logic [31:0]   log_d[$];
  int            wr_cnt   = 0;
  int            ok_cnt   = 0;
  int            ferr_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_arm(input logic [AW-1:0] s, input logic [AW-1:0] e);
    if (!exp_busy) begin
      m_armed  = 1'b1;
      m_addr   = s;
      m_end    = e;
      m_nb     = 0;
      exp_busy = 1'b1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    if (m_armed) begin
      m_word[8*m_nb +: 8] = b;
      m_nb++;
      if (m_nb == 4) begin
        w.a = m_addr; w.d = m_word; w.last = (m_addr == m_end);
        exp_q.push_back(w);
        m_nb = 0;
        if (w.last) m_armed = 1'b0;
        else        m_addr  = m_addr + 16'd1;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_armed = 1'b0; m_nb = 0; exp_busy = 1'b0; ferr_pend = 0; since_last = 100;
  endtask

  task automatic drive(input logic v, input int n);
    rs232_rx = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) model_byte(b);
    else         ferr_pend++;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop_ok, CPB);
    drive(1'b1, CPB);
  endtask

  task automatic arm(input logic [AW-1:0] s, input logic [AW-1:0] e);
    startAddr = s; endAddr = e; recvSig = 1'b1;
    @(posedge clk);
    #2;
    recvSig = 1'b0;
    model_arm(s, e);
    check("busy_after_arm", busy, 1);
  endtask

  task automatic wait_quiet(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || exp_busy || ferr_pend != 0) && k < 400) begin
      @(posedge clk);
      #2;
      k++;
    end
    check({tag, "_quiet"}, (k < 400), 1);
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic monitor();
    wr_t e;
    bit  ok_exp;
    forever begin
      @(negedge clk);
      if (since_last < 100) since_last++;
      ok_exp = (since_last == 1);
      if (since_last == 2) begin
        exp_busy = 1'b0;
        check("busy_after_ok", busy, 0);
      end
      if (ok || ok_exp) begin
        check("ok_pulse", ok, ok_exp);
        check("busy_at_ok", busy, 1);
      end
      if (ok) ok_cnt++;
      if (write) begin
        wr_cnt++;
        log_a.push_back(addr);
        log_d.push_back(data);
        check("busy_at_wr", busy, 1);
        if (exp_q.size() == 0) begin
          check("wr_unexpected", write, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", addr, e.a);
          check("wr_data", data, e.d);
          if (e.last) since_last = 0;
        end
      end
      if (frameErr) begin
        ferr_cnt++;
        check("frameErr_expected", (ferr_pend > 0), 1);
        if (ferr_pend > 0) ferr_pend--;
      end
    end
  endtask

  task automatic stimulus();
    int wr0, ok0, fe0;
    logic [7:0] b;

    // Reset state
    rst_n = 1'b1; recvSig = 1'b0; startAddr = '0; endAddr = '0; rs232_rx = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_write", write, 0);
    check("rst_ok", ok, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_ferr", frameErr, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    // Single word
    log_a.delete(); log_d.delete(); ok0 = ok_cnt;
    arm(16'h1000, 16'h1000);
    send_frame(8'h78, 1'b1);
    send_frame(8'h56, 1'b1);
    send_frame(8'h34, 1'b1);
    send_frame(8'h12, 1'b1);
    wait_quiet("single");
    check("single_nwr", log_a.size(), 1);
    check("single_addr", log_a[0], 16'h1000);
    check("single_data", log_d[0], 32'h12345678);
    check("single_ok", ok_cnt - ok0, 1);
    check("single_busy", busy, 0);

    // Sixteen words with random bytes and an ignored mid-session arm
    log_a.delete(); log_d.delete(); ok0 = ok_cnt;
    arm(16'h1000, 16'h100F);
    for (int i = 0; i < 64; i++) begin
      if (i == 20) arm(16'h5555, 16'h5555);
      b = 8'($urandom);
      send_frame(b, 1'b1);
    end
    wait_quiet("multi");
    check("multi_nwr", log_a.size(), 16);
    check("multi_first", log_a[0], 16'h1000);
    check("multi_last", log_a[15], 16'h100F);
    check("multi_ok", ok_cnt - ok0, 1);

    // Address wrap
    log_a.delete(); log_d.delete(); ok0 = ok_cnt;
    arm(16'hFFFE, 16'h0001);
    for (int i = 0; i < 16; i++) send_frame(8'(8'hA0 + i), 1'b1);
    wait_quiet("wrap");
    check("wrap_nwr", log_a.size(), 4);
    check("wrap_a0", log_a[0], 16'hFFFE);
    check("wrap_a1", log_a[1], 16'hFFFF);
    check("wrap_a2", log_a[2], 16'h0000);
    check("wrap_a3", log_a[3], 16'h0001);
    check("wrap_d3", log_d[3], 32'hAFAEADAC);
    check("wrap_ok", ok_cnt - ok0, 1);

    // Frame error while armed, then a good word
    log_a.delete(); log_d.delete(); fe0 = ferr_cnt;
    arm(16'h3000, 16'h3000);
    send_frame(8'hAA, 1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    wait_quiet("ferr");
    check("ferr_cnt", ferr_cnt - fe0, 1);
    check("ferr_nwr", log_a.size(), 1);
    check("ferr_addr", log_a[0], 16'h3000);
    check("ferr_data", log_d[0], 32'h44332211);

    // Unarmed bytes and a short glitch
    wr0 = wr_cnt; fe0 = ferr_cnt;
    for (int i = 0; i < 4; i++) send_frame(8'(8'h5A ^ i), 1'b1);
    drive(1'b0, 1);
    drive(1'b1, 3 * CPB);
    check("unarmed_nwr", wr_cnt - wr0, 0);
    check("glitch_ferr", ferr_cnt - fe0, 0);
    check("unarmed_busy", busy, 0);

    // Reset mid-word, then re-arm
    log_a.delete(); log_d.delete();
    arm(16'h2000, 16'h2000);
    send_frame(8'hDE, 1'b1);
    send_frame(8'hAD, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", addr, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_write", write, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    arm(16'h2000, 16'h2000);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    wait_quiet("rearm");
    check("rearm_nwr", log_a.size(), 1);
    check("rearm_addr", log_a[0], 16'h2000);
    check("rearm_data", log_d[0], 32'h04030201);
  endtask

  initial begin
    fork
      stimulus();
      monitor();
      begin
        repeat (90000) @(posedge clk);
        n_cmp++;
        n_fail++;
        $display("FAIL global_timeout: got 0, expected stimulus completion");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/recv_pc_to_ram32.md
RECV_PC_TO_RAM32 -- requirements
Module: recv_pc_to_ram32

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter WIDTHofADDR, default 16, RAM address width.
REQ-003 clk  input  1  100 MHz system clock; all state on rising edge; one clock; reset is asynchronous and active-low.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 recvSig  input  1  one-cycle arm pulse; starts a receive session.
REQ-006 startAddr  input  WIDTHofADDR  first RAM address written; sampled on the accepted recvSig.
REQ-007 endAddr  input  WIDTHofADDR  last RAM address written; sampled on the accepted recvSig.
REQ-008 rs232_rx  input  1  UART RX line from PC; idle high.
REQ-009 write  output  1  one-cycle RAM write strobe.
REQ-010 addr  output  WIDTHofADDR  RAM address; valid while write=1.
REQ-011 data  output  32  RAM write data; valid while write=1.
REQ-012 busy  output  1  high from the accepted recvSig until ok.
REQ-013 ok  output  1  one-cycle pulse after the endAddr word is written.
REQ-014 frameErr  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-015 rs232_rx passes a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-016 UART format is 8N1, LSB first.
REQ-017 Bit FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-018 RX_IDLE -> RX_START on a synchronized 1->0 transition.
REQ-019 RX_START re-samples at CLKS_PER_BIT/2: low -> RX_DATA; high -> RX_IDLE (glitch, no error).
REQ-020 RX_DATA samples each of 8 bits every CLKS_PER_BIT cycles, measured from the start-bit midpoint.
REQ-021 RX_STOP samples once more, then returns to RX_IDLE.
  - stop=1: byte valid.
  - stop=0: frameErr pulses the next cycle, byte discarded, byte counter unchanged.
REQ-022 The bit FSM runs whether or not armed; valid bytes received while busy=0 are discarded.
REQ-023 Word FSM states: W_IDLE, W_RECV, W_WRITE, W_DONE.
REQ-024 W_IDLE + recvSig: latch startAddr into addr and endAddr into the end register, clear byte count, busy<=1, -> W_RECV.
REQ-025 W_RECV, per valid byte n (0..3): byte 0 -> data[7:0], byte 1 -> [15:8], byte 2 -> [23:16], byte 3 -> [31:24] (little-endian, matching the PC send order).
REQ-026 Fourth valid byte -> W_WRITE; write=1 for exactly one cycle, the cycle after the stop-bit sample.
REQ-027 In W_WRITE:
  - addr != endAddr: addr <= addr+1 mod 2^WIDTHofADDR, byte count cleared, -> W_RECV.
  - addr == endAddr: -> W_DONE.
REQ-028 W_DONE: ok=1 for one cycle, busy<=0, -> W_IDLE; addr and data hold their last values.
REQ-029 endAddr < startAddr: addresses wrap through 2^WIDTHofADDR-1 to 0 up to endAddr; startAddr == endAddr writes exactly one word.
REQ-030 recvSig while busy=1 is ignored; no relatch.
REQ-031 A byte completing in the same cycle as the accepted recvSig is discarded.
REQ-032 There is no inter-byte timeout; a partial word waits indefinitely.

Reset
REQ-033 rst_n=0 takes effect immediately, mid-frame or mid-session:
  - write, ok, frameErr, busy = 0; addr = 0; data = 0; byte count = 0.
  - Both FSMs to idle; synchronizer flops = 1.
REQ-034 After rst_n rises, the session must be re-armed; the partial word is lost.

Verification
REQ-035 Arm startAddr=0x1000, endAddr=0x1000; send 0x78,0x56,0x34,0x12 -> one write, addr=0x1000, data=0x12345678; ok one cycle later; busy low.
REQ-036 Arm 0x1000..0x100F; send 64 random bytes -> 16 writes at 0x1000..0x100F, data matching the packed bytes, a single ok.
REQ-037 Arm 0xFFFE..0x0001 -> writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001, then ok.
REQ-038 Armed; send a byte with stop=0 -> frameErr one cycle; next 4 good bytes form word 0 at startAddr.
REQ-039 Unarmed; send 4 bytes -> no write; 1-cycle low glitch (< CLKS_PER_BIT/2) on rx -> no byte, no frameErr.
REQ-040 Assert rst_n=0 after byte 2 of a word -> outputs zero at once; re-arm plus 4 bytes -> a clean word at startAddr.
